// File: rtl/axi_pkg.sv
// Shared definitions for the handshake-to-AXI4-Lite bridge.
//   hs_state_e  : 4-bit state encoding for the bridge FSM
//   RESP_*      : AXI response codes
//   resp_is_err : 1 for SLVERR/DECERR, 0 for OKAY/EXOKAY
package axi_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_AR      = 4'd1,
    ST_R       = 4'd2,
    ST_W_AW    = 4'd3,
    ST_W_ONLY  = 4'd4,
    ST_AW_ONLY = 4'd5,
    ST_B       = 4'd6,
    ST_ACK     = 4'd7
  } hs_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/hs_2_axi_stats.sv
// Completion counters for the handshake-to-AXI4-Lite bridge.
// Only instantiated when HS_2_AXI_STATS_EN is defined.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   ack_i             high during the bridge's ACK cycle
//   rd_i              completing transaction was a read
//   err_i             completing transaction returned an error
//   stat_rd_o         completed reads   (wraps at 2^32)
//   stat_wr_o         completed writes  (wraps at 2^32)
//   stat_err_o        error completions (wraps at 2^32)
module hs_2_axi_stats (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ack_i,
  input  logic        rd_i,
  input  logic        err_i,
  output logic [31:0] stat_rd_o,
  output logic [31:0] stat_wr_o,
  output logic [31:0] stat_err_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_rd_o  <= '0;
      stat_wr_o  <= '0;
      stat_err_o <= '0;
    end else if (ack_i) begin
      if (rd_i) stat_rd_o <= stat_rd_o + 32'd1;
      else      stat_wr_o <= stat_wr_o + 32'd1;
      if (err_i) stat_err_o <= stat_err_o + 32'd1;
    end
  end

endmodule

// File: rtl/hs_2_axi_lite.sv
// Single-beat handshake to AXI4-Lite master bridge.
// Captures one read or write request in IDLE and runs it as one AXI4-Lite
// transaction; all AXI outputs are registered and stable while VALID is high.
// Optional macro HS_2_AXI_STATS_EN adds completion counters
// (stat_rd_o, stat_wr_o, stat_err_o).
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   hs_read_i, hs_write_i             request strobes (sampled in IDLE only)
//   hs_addr_i, hs_data_i, hs_be_i     request address, write data, byte enables
//   hs_ready_o, hs_err_o              one-cycle completion pulse and error flag
//   hs_data_o                         last read data
//   ar*/r*/aw*/w*/b*                  AXI4-Lite master channels
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | waiting for a request
// ST_AR      | read address valid, waiting for arready
// ST_R       | rready high, waiting for read data
// ST_W_AW    | write address and data both valid
// ST_W_ONLY  | address accepted, waiting for wready
// ST_AW_ONLY | data accepted, waiting for awready
// ST_B       | bready high, waiting for write response
// ST_ACK     | completion pulse to the requester
module hs_2_axi_lite
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // 32 or 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                hs_read_i,
  input  logic                hs_write_i,
  input  logic [ADDR_W-1:0]   hs_addr_i,
  input  logic [DATA_W-1:0]   hs_data_i,
  input  logic [DATA_W/8-1:0] hs_be_i,
  output logic                hs_ready_o,
  output logic                hs_err_o,
  output logic [DATA_W-1:0]   hs_data_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  output logic [ADDR_W-1:0]   araddr_o,
  input  logic                rvalid_i,
  output logic                rready_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic                bvalid_i,
  output logic                bready_o,
  input  logic [1:0]          bresp_i
`ifdef HS_2_AXI_STATS_EN
  ,
  output logic [31:0]         stat_rd_o,
  output logic [31:0]         stat_wr_o,
  output logic [31:0]         stat_err_o
`endif
);

  hs_state_e state;

`ifdef HS_2_AXI_STATS_EN
  logic op_rd;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      hs_ready_o <= 1'b0;
      hs_err_o   <= 1'b0;
      hs_data_o  <= '0;
      arvalid_o  <= 1'b0;
      araddr_o   <= '0;
      rready_o   <= 1'b0;
      awvalid_o  <= 1'b0;
      awaddr_o   <= '0;
      wvalid_o   <= 1'b0;
      wdata_o    <= '0;
      wstrb_o    <= '0;
      bready_o   <= 1'b0;
`ifdef HS_2_AXI_STATS_EN
      op_rd      <= 1'b0;
`endif
    end else begin
      // Completion outputs are only ever set on the transition into ACK,
      // so hs_err_o is automatically 0 outside ACK.
      hs_ready_o <= 1'b0;
      hs_err_o   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (hs_read_i) begin
            araddr_o  <= hs_addr_i;
            arvalid_o <= 1'b1;
`ifdef HS_2_AXI_STATS_EN
            op_rd     <= 1'b1;
`endif
            state     <= ST_AR;
          end else if (hs_write_i) begin
            awaddr_o  <= hs_addr_i;
            wdata_o   <= hs_data_i;
            wstrb_o   <= hs_be_i;
            awvalid_o <= 1'b1;
            wvalid_o  <= 1'b1;
`ifdef HS_2_AXI_STATS_EN
            op_rd     <= 1'b0;
`endif
            state     <= ST_W_AW;
          end
        end

        ST_AR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state     <= ST_R;
          end
        end

        ST_R: begin
          if (rvalid_i) begin
            hs_data_o  <= rdata_i;
            rready_o   <= 1'b0;
            hs_ready_o <= 1'b1;
            hs_err_o   <= resp_is_err(rresp_i);
            state      <= ST_ACK;
          end
        end

        // Both valids are high here, so each ready alone completes its channel.
        ST_W_AW: begin
          if (awready_i && wready_i) begin
            awvalid_o <= 1'b0;
            wvalid_o  <= 1'b0;
            bready_o  <= 1'b1;
            state     <= ST_B;
          end else if (awready_i) begin
            awvalid_o <= 1'b0;
            state     <= ST_W_ONLY;
          end else if (wready_i) begin
            wvalid_o  <= 1'b0;
            state     <= ST_AW_ONLY;
          end
        end

        ST_W_ONLY: begin
          if (wready_i) begin
            wvalid_o <= 1'b0;
            bready_o <= 1'b1;
            state    <= ST_B;
          end
        end

        ST_AW_ONLY: begin
          if (awready_i) begin
            awvalid_o <= 1'b0;
            bready_o  <= 1'b1;
            state     <= ST_B;
          end
        end

        ST_B: begin
          if (bvalid_i) begin
            bready_o   <= 1'b0;
            hs_ready_o <= 1'b1;
            hs_err_o   <= resp_is_err(bresp_i);
            state      <= ST_ACK;
          end
        end

        ST_ACK: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef HS_2_AXI_STATS_EN
  hs_2_axi_stats u_stats (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ack_i      (state == ST_ACK),
    .rd_i       (op_rd),
    .err_i      (hs_err_o),
    .stat_rd_o  (stat_rd_o),
    .stat_wr_o  (stat_wr_o),
    .stat_err_o (stat_err_o)
  );
`endif

endmodule
